// File: rtl/mini_text_renderer.sv
// mini_text_renderer: overlays a short string of font glyphs on the VGA pixel stream.
// Stage 0 finds the pixel's position inside the text box, stage 1 addresses the
// external combinational font ROM, and stage 2 picks the font bit. This gives text_on
// and text_de exactly two clocks after the pixel coordinates arrive.
module mini_text_renderer #(
  parameter int MAX_CHARS   = 16,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = $clog2(MAX_CHARS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              DE,
  input  logic [9:0]        org_x,
  input  logic [9:0]        org_y,
  input  logic [4:0]        str_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [5:0]        wr_char,
  output logic [5:0]        char_idx,
  output logic [2:0]        row_addr,
  input  logic [7:0]        row_data,
  output logic              text_on,
  output logic              text_de
);

  // Glyph code for which the font ROM returns all-zero rows
  localparam logic [5:0]  BLANK       = 6'h3F;
  // log2 of the on-screen glyph width in pixels
  localparam int          GLYPH_SHIFT = 3 + SCALE_SHIFT;
  localparam logic [15:0] BOX_H       = 16'(8 << SCALE_SHIFT);

  // String buffer. Each slot needs a reset value, so the buffer is built from flops
  // and not from a RAM.
  logic [5:0] glyph_buf [MAX_CHARS];

  for (genvar gi = 0; gi < MAX_CHARS; gi++) begin : g_slot
    logic [5:0] slot_reg;

    // Load this slot when its address is written. An address at or above MAX_CHARS
    // matches no slot and is dropped.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_reg <= BLANK;
      end else if (wr_en && (32'(wr_addr) == gi)) begin
        slot_reg <= wr_char;
      end
    end

    assign glyph_buf[gi] = slot_reg;
  end

  // Stage 0 signals
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [15:0]       len_c;
  logic [15:0]       box_w;
  logic              in_box;
  logic [ADDR_W-1:0] col_idx;
  logic [2:0]        px;
  logic [2:0]        row;

  // Stage 1 / stage 2 pipeline registers
  logic [2:0] px_reg;
  logic       in_box_reg;
  logic       de_reg;

  // Stage 0: pixel offset from the box origin, the hit test, and the glyph cell coordinates
  always_comb begin
    dx      = {1'b0, x_pixel} - {1'b0, org_x};
    dy      = {1'b0, y_pixel} - {1'b0, org_y};
    len_c   = ({11'd0, str_len} > 16'(MAX_CHARS)) ? 16'(MAX_CHARS) : {11'd0, str_len};
    box_w   = len_c << GLYPH_SHIFT;
    // Bit 10 set means the 11-bit difference is negative (pixel left of or above the box)
    in_box  = !dx[10] && !dy[10] && ({6'd0, dx[9:0]} < box_w) && ({6'd0, dy[9:0]} < BOX_H);
    col_idx = ADDR_W'(dx[9:0] >> GLYPH_SHIFT);
    px      = dx[SCALE_SHIFT+2:SCALE_SHIFT];
    row     = dy[SCALE_SHIFT+2:SCALE_SHIFT];
  end

  // Stage 1: address the font ROM. This read sees the buffer contents from before any
  // write on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_idx   <= BLANK;
      row_addr   <= 3'd0;
      px_reg     <= 3'd0;
      in_box_reg <= 1'b0;
      de_reg     <= 1'b0;
    end else begin
      char_idx   <= in_box ? glyph_buf[col_idx] : BLANK;
      row_addr   <= row;
      px_reg     <= px;
      in_box_reg <= in_box;
      de_reg     <= DE;
    end
  end

  // Stage 2: select this pixel's font bit (bit 7 is the leftmost) and gate it with
  // box and display enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      text_on <= 1'b0;
      text_de <= 1'b0;
    end else begin
      text_on <= in_box_reg & de_reg & row_data[3'd7 - px_reg];
      text_de <= de_reg;
    end
  end

endmodule

// File: tb/tb_mini_text_renderer.sv
// tb_mini_text_renderer: scoreboard bench for mini_text_renderer with a font ROM stand-in.
// The driver queues the expected (text_on, text_de) for each pixel it presents, and a
// separate monitor checks each entry when the DUT produces that pixel's output.
module tb_mini_text_renderer;
  localparam int SCALE = 2;           // 1 << SCALE_SHIFT
  localparam int CELL  = 8 * SCALE;   // on-screen glyph size in pixels

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pixel, y_pixel, org_x, org_y;
  logic       DE;
  logic [4:0] str_len;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [5:0] wr_char;
  logic [5:0] char_idx;
  logic [2:0] row_addr;
  logic [7:0] row_data;
  logic       text_on, text_de;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  typedef struct {
    int   due;
    logic on;
    logic de;
    int   x;
    int   y;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Reference model state: string buffer contents and the settings applied to the next pixel
  int mbuf [16];
  int set_ox, set_oy, set_len;

  mini_text_renderer #(.MAX_CHARS(16), .SCALE_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(DE),
    .org_x(org_x), .org_y(org_y), .str_len(str_len), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .char_idx(char_idx), .row_addr(row_addr), .row_data(row_data),
    .text_on(text_on), .text_de(text_de)
  );

  always #5 clk = ~clk;

  // Count rising edges
  always @(posedge clk) cycle <= cycle + 1;

  // Font ROM stand-in: a few fixed glyphs, a hash pattern for all other codes,
  // and all-zero rows for the blank code
  function automatic logic [7:0] font_row(input logic [5:0] c, input logic [2:0] r);
    logic [7:0] h;
    case (c)
      6'd0:
        case (r)
          3'd1: return 8'h3C;
          3'd2: return 8'h66;
          3'd3: return 8'h6E;
          3'd4: return 8'h76;
          3'd5: return 8'h66;
          3'd6: return 8'h3C;
          default: return 8'h00;
        endcase
      6'd1:
        case (r)
          3'd0: return 8'h18;
          3'd1: return 8'h38;
          3'd7: return 8'h3E;
          default: return 8'h18;
        endcase
      6'd13:
        case (r)
          3'd1: return 8'hC3;
          3'd2: return 8'hA5;
          3'd3: return 8'h99;
          default: return 8'h81;
        endcase
      6'h3F: return 8'h00;
      default: begin
        h = {2'b0, c} * 8'd29 + {5'b0, r} * 8'd53;
        return h ^ 8'h5A;
      end
    endcase
  endfunction

  assign row_data = font_row(char_idx, row_addr);

  // Expected text_on for a pixel, computed with integer geometry
  function automatic logic model_on(input int x, input int y, input logic de,
                                    input int ox, input int oy, input int len);
    int dx, dy, n;
    logic [7:0] bits;
    dx = x - ox;
    dy = y - oy;
    n  = (len > 16) ? 16 : len;
    if (!de) return 1'b0;
    if (dx < 0 || dy < 0 || dx >= n * CELL || dy >= CELL) return 1'b0;
    bits = font_row(6'(mbuf[dx / CELL]), 3'((dy / SCALE) % 8));
    return bits[7 - (dx / SCALE) % 8];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present one pixel (and an optional buffer write) for one clock, and queue its expectation
  task automatic pixel(input int x, input int y, input logic de,
                       input logic we = 1'b0, input int wa = 0, input int wc = 0);
    @(posedge clk);
    #1;
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    DE      = de;
    org_x   = 10'(set_ox);
    org_y   = 10'(set_oy);
    str_len = 5'(set_len);
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_char = 6'(wc);
    if (!reset) begin
      sb.push_back('{due: cycle + 2, on: model_on(x, y, de, set_ox, set_oy, set_len),
                     de: de, x: x, y: y});
      // Apply the write after computing the expectation: this pixel still sees the old glyph
      if (we && wa < 16) mbuf[wa] = wc;
    end
  endtask

  // Monitor: compare the queued expectation that falls due on this cycle
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due < cycle) begin
        e = sb.pop_front();
        checks++;
        $display("FAIL missed_pixel (%0d,%0d): got no output slot required due cycle %0d",
                 e.x, e.y, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cycle) begin
        e = sb.pop_front();
        $display("px (%0d,%0d) de=%0b text_on=%0b exp_on=%0b text_de=%0b",
                 e.x, e.y, e.de, text_on, e.on, text_de);
        chk($sformatf("text_on(%0d,%0d)", e.x, e.y), {7'd0, text_on}, {7'd0, e.on});
        chk($sformatf("text_de(%0d,%0d)", e.x, e.y), {7'd0, text_de}, {7'd0, e.de});
      end
    end
  end

  initial begin
    reset   = 1'b1;
    x_pixel = '0; y_pixel = '0; DE = 1'b0; org_x = '0; org_y = '0;
    str_len = '0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
    set_ox = 100; set_oy = 50; set_len = 1;
    foreach (mbuf[i]) mbuf[i] = 63;

    // Reset held: outputs stay cleared while lit-looking pixels stream in
    for (int i = 0; i < 6; i++) begin
      pixel(104 + i, 64, 1'b1);
      #2;
      chk("rst_text_on", {7'd0, text_on}, 8'd0);
      chk("rst_text_de", {7'd0, text_de}, 8'd0);
      chk("rst_char_idx", {2'd0, char_idx}, 8'h3F);
    end
    reset = 1'b0;

    // Zero-length string over a coarse full-frame sweep
    set_len = 0;
    for (int y = 0; y < 480; y += 11)
      for (int x = 0; x < 640; x += 13)
        pixel(x, y, 1'b1);

    // Glyph '1' in slot 0
    pixel(0, 0, 1'b0, 1'b1, 0, 1);
    set_len = 1;
    for (int x = 102; x <= 113; x++) pixel(x, 50, 1'b1);
    for (int x = 102; x <= 115; x++) pixel(x, 64, 1'b1);

    // Box edges with 'M' in slot 1
    pixel(0, 0, 1'b0, 1'b1, 1, 13);
    set_len = 2;
    for (int x = 99; x <= 133; x++) pixel(x, 50, 1'b1);
    pixel(116, 49, 1'b1);
    pixel(116, 65, 1'b1);
    pixel(116, 66, 1'b1);

    // Write collision: same-cycle render of slot 0 sees the old glyph
    set_len = 1;
    pixel(106, 50, 1'b1);
    pixel(106, 50, 1'b1, 1'b1, 0, 0);
    pixel(107, 50, 1'b1);
    pixel(106, 50, 1'b1);

    // Display-enable toggling keeps two-cycle alignment
    pixel(104, 52, 1'b1);
    pixel(104, 52, 1'b0);
    pixel(104, 52, 1'b1);
    pixel(105, 52, 1'b0);
    pixel(106, 52, 1'b1);
    pixel(107, 52, 1'b1);

    // Random origins, lengths (including clamped ones), writes and pixels
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        set_ox  = $urandom_range(110, 90);
        set_oy  = $urandom_range(60, 40);
        set_len = $urandom_range(20, 0);
      end
      pixel($urandom_range(set_ox + 270, set_ox - 4), $urandom_range(set_oy + 20, set_oy - 3),
            ($urandom_range(3) != 0), ($urandom_range(2) == 0),
            $urandom_range(15, 0), $urandom_range(63, 0));
    end

    // Mid-frame reset while a lit pixel is on the output
    set_ox = 100; set_oy = 50; set_len = 1;
    pixel(0, 0, 1'b0, 1'b1, 0, 1);
    repeat (3) pixel(106, 50, 1'b1);
    #1;
    chk("pre_reset_text_on", {7'd0, text_on}, 8'd1);
    reset = 1'b1;
    sb.delete();
    foreach (mbuf[i]) mbuf[i] = 63;
    #1;
    chk("async_rst_text_on", {7'd0, text_on}, 8'd0);
    chk("async_rst_text_de", {7'd0, text_de}, 8'd0);
    chk("async_rst_char_idx", {2'd0, char_idx}, 8'h3F);
    pixel(106, 50, 1'b1);
    pixel(106, 50, 1'b1);
    #2;
    reset = 1'b0;
    for (int x = 102; x <= 113; x++) pixel(x, 50, 1'b1);
    for (int x = 102; x <= 113; x++) pixel(x, 64, 1'b1);

    // Let the last pixels drain through the pipeline
    pixel(0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
